// File: rtl/effect_switch_ctrl.sv
// Footswitch-driven effect path selector with click-free switching:
// fade old path out, flush the new path's delay line, fade the new path in.
module effect_switch_ctrl #(
    parameter int NUM_FX     = 4,
    parameter int SEL_W      = 2,
    parameter int RAMP_SHIFT = 4,
    parameter int DEBOUNCE   = 64,
    parameter int FLUSH_LEN  = 32
) (
    input  logic                     sample_clock,
    input  logic                     reset,
    input  logic                     footswitch,
    input  logic [NUM_FX*16-1:0]     fx_in,
    output logic signed [15:0]       output_sample,
    output logic [SEL_W-1:0]         fx_active,
    output logic [NUM_FX-1:0]        fx_flush,
    output logic                     busy
);

    localparam int GW = RAMP_SHIFT + 1;
    localparam int PW = 17 + RAMP_SHIFT;
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int FW = $clog2(FLUSH_LEN + 1);
    localparam logic [GW-1:0] GAIN_FULL = {1'b1, {RAMP_SHIFT{1'b0}}};

    typedef enum logic [1:0] {PLAY, FADE_OUT, FLUSH, FADE_IN} state_t;

    state_t state, state_next;

    logic                 sync1, sync2;
    logic [DW-1:0]        db_cnt;
    logic                 db_level, db_level_d;
    logic                 press;
    logic                 pending;
    logic [GW-1:0]        gain;
    logic [FW-1:0]        flush_cnt;
    logic signed [15:0]   sample;
    logic signed [PW-1:0] product;

    always_ff @(posedge sample_clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= footswitch;
            sync2 <= sync1;
        end
    end

    // Level only moves after DEBOUNCE back-to-back cycles of disagreement.
    always_ff @(posedge sample_clock) begin
        if (reset) begin
            db_cnt     <= '0;
            db_level   <= 1'b0;
            db_level_d <= 1'b0;
        end else begin
            db_level_d <= db_level;
            if (sync2 != db_level) begin
                if (db_cnt == DW'(DEBOUNCE - 1)) begin
                    db_level <= sync2;
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign press = db_level & ~db_level_d;

    always_ff @(posedge sample_clock) begin
        if (reset) state <= PLAY;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            PLAY:     if (press || pending)                 state_next = FADE_OUT;
            FADE_OUT: if (gain == '0)                       state_next = FLUSH;
            FLUSH:    if (flush_cnt == FW'(FLUSH_LEN - 1))  state_next = FADE_IN;
            FADE_IN:  if (gain == GAIN_FULL)                state_next = PLAY;
            default:                                        state_next = PLAY;
        endcase
    end

    always_comb begin
        busy     = (state != PLAY);
        fx_flush = '0;
        if (state == FLUSH) fx_flush[fx_active] = 1'b1;
    end

    assign sample  = fx_in[16*fx_active +: 16];
    assign product = PW'(sample) * PW'($signed({1'b0, gain}));

    always_ff @(posedge sample_clock) begin
        if (reset) begin
            gain          <= GAIN_FULL;
            fx_active     <= '0;
            flush_cnt     <= '0;
            pending       <= 1'b0;
            output_sample <= '0;
        end else begin
            output_sample <= 16'(product >>> RAMP_SHIFT);
            if (state == PLAY) pending <= 1'b0;
            else if (press)    pending <= 1'b1;
            case (state)
                PLAY:     gain <= (press || pending) ? GAIN_FULL - 1'b1 : GAIN_FULL;
                FADE_OUT: begin
                    if (gain == '0)
                        fx_active <= (fx_active == SEL_W'(NUM_FX - 1)) ? '0 : fx_active + 1'b1;
                    else
                        gain <= gain - 1'b1;
                end
                FLUSH: begin
                    if (flush_cnt == FW'(FLUSH_LEN - 1)) begin
                        flush_cnt <= '0;
                        gain      <= GW'(1);
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                FADE_IN:  if (gain != GAIN_FULL) gain <= gain + 1'b1;
                default:  gain <= GAIN_FULL;
            endcase
        end
    end

endmodule

// File: tb/tb_effect_switch_ctrl.sv
// Self-checking bench for effect_switch_ctrl; a second instance with a short
// debounce lets two presses land inside one switch sequence.
module tb_effect_switch_ctrl;

    logic               clk = 1'b0;
    logic               reset;
    logic               footswitch;
    logic               footswitch_f;
    logic [63:0]        fx_in;
    logic signed [15:0] output_sample, output_sample_f;
    logic [1:0]         fx_active, fx_active_f;
    logic [3:0]         fx_flush, fx_flush_f;
    logic               busy, busy_f;

    int                 n_cmp = 0;
    int                 n_bad = 0;
    logic signed [15:0] exp_q[$];
    int                 vals[4];

    always #5 clk = ~clk;

    effect_switch_ctrl dut (
        .sample_clock(clk), .reset(reset), .footswitch(footswitch), .fx_in(fx_in),
        .output_sample(output_sample), .fx_active(fx_active), .fx_flush(fx_flush), .busy(busy)
    );

    effect_switch_ctrl #(.DEBOUNCE(2)) dut_fast (
        .sample_clock(clk), .reset(reset), .footswitch(footswitch_f), .fx_in(fx_in),
        .output_sample(output_sample_f), .fx_active(fx_active_f), .fx_flush(fx_flush_f),
        .busy(busy_f)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_paths(input int a, input int b, input int c, input int d);
        vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = d;
        fx_in = {16'(d), 16'(c), 16'(b), 16'(a)};
    endtask

    function automatic int floor16(input int p);
        int q;
        q = p / 16;
        if (p < 0 && (p % 16) != 0) q = q - 1;
        return q;
    endfunction

    task automatic test_reset;
        logic signed [15:0] e;
        reset = 1'b1;
        set_paths(1000, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(16'sd0);
            tick;
            e = exp_q.pop_front();
            n_cmp++;
            if (output_sample !== e) begin
                n_bad++;
                $display("FAIL reset_out: got %0d, expected %0d", output_sample, e);
            end
            n_cmp++;
            if (fx_active !== 2'd0 || busy !== 1'b0 || fx_flush !== 4'd0) begin
                n_bad++;
                $display("FAIL reset_state: got act=%0d busy=%0b flush=%b, expected 0/0/0000",
                         fx_active, busy, fx_flush);
            end
        end
        reset = 1'b0;
        exp_q.push_back(16'sd1000);
        tick;
        e = exp_q.pop_front();
        n_cmp++;
        if (output_sample !== e || fx_active !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_release: got out=%0d act=%0d, expected %0d/0",
                     output_sample, fx_active, e);
        end
    endtask

    task automatic test_debounce;
        int busy_seen = 0;
        footswitch = 1'b1;
        for (int i = 0; i < 10; i++) begin tick; if (busy) busy_seen++; end
        footswitch = 1'b0;
        for (int i = 0; i < 80; i++) begin tick; if (busy) busy_seen++; end
        n_cmp++;
        if (busy_seen !== 0) begin
            n_bad++;
            $display("FAIL short_pulse: got %0d busy cycles, expected 0", busy_seen);
        end
    endtask

    // Press the main footswitch, then check the whole 64-cycle switch against a model.
    task automatic switch_and_check(input int from, output int lat);
        int to;
        int busy_cnt;
        logic signed [15:0] e;
        logic [3:0] ef;
        to = (from + 1) % 4;
        exp_q.delete();
        footswitch = 1'b1;
        lat = 0;
        while (busy !== 1'b1 && lat < 100) begin tick; lat++; end
        footswitch = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL switch_start: got no busy after %0d cycles, expected busy", lat);
            return;
        end
        exp_q.push_back(16'(vals[from]));
        for (int i = 1; i <= 64; i++) begin
            if (i <= 16)      exp_q.push_back(16'(floor16(vals[from] * (16 - i))));
            else if (i <= 48) exp_q.push_back(16'sd0);
            else              exp_q.push_back(16'(floor16(vals[to] * (i - 48))));
        end
        busy_cnt = 0;
        for (int i = 0; i <= 64; i++) begin
            if (i > 0) tick;
            if (busy) busy_cnt++;
            e = exp_q.pop_front();
            n_cmp++;
            if (output_sample !== e) begin
                n_bad++;
                $display("FAIL switch_out[%0d]: got %0d, expected %0d", i, output_sample, e);
            end
            ef = (i >= 16 && i <= 47) ? 4'(1 << to) : 4'd0;
            n_cmp++;
            if (fx_flush !== ef || fx_active !== 2'((i >= 16) ? to : from)) begin
                n_bad++;
                $display("FAIL switch_ctl[%0d]: got flush=%b act=%0d, expected %b/%0d",
                         i, fx_flush, fx_active, ef, (i >= 16) ? to : from);
            end
        end
        n_cmp++;
        if (busy_cnt !== 64) begin
            n_bad++;
            $display("FAIL busy_len: got %0d, expected 64", busy_cnt);
        end
        repeat (12) tick;
    endtask

    task automatic test_switch;
        int lat;
        set_paths(16000, -8000, 300, -300);
        switch_and_check(0, lat);
        n_cmp++;
        if (lat < 66 || lat > 67) begin
            n_bad++;
            $display("FAIL press_latency: got %0d, expected 66..67", lat);
        end
    endtask

    task automatic test_pending;
        int n;
        footswitch_f = 1'b1;
        n = 0;
        while (busy_f !== 1'b1 && n < 30) begin tick; n++; end
        footswitch_f = 1'b0;
        n_cmp++;
        if (busy_f !== 1'b1) begin
            n_bad++;
            $display("FAIL pend_start: got no busy after %0d cycles, expected busy", n);
            return;
        end
        repeat (48) tick;
        footswitch_f = 1'b1; repeat (4) tick;
        footswitch_f = 1'b0; repeat (4) tick;
        footswitch_f = 1'b1; repeat (4) tick;
        footswitch_f = 1'b0; repeat (4) tick;
        n_cmp++;
        if (busy_f !== 1'b0 || fx_active_f !== 2'd1) begin
            n_bad++;
            $display("FAIL pend_play: got busy=%0b act=%0d, expected 0/1", busy_f, fx_active_f);
        end
        tick;
        n_cmp++;
        if (busy_f !== 1'b1) begin
            n_bad++;
            $display("FAIL pend_restart: got busy=%0b, expected 1", busy_f);
        end
        n = 0;
        while (busy_f === 1'b1 && n < 100) begin tick; n++; end
        n_cmp++;
        if (n !== 64 || fx_active_f !== 2'd2) begin
            n_bad++;
            $display("FAIL pend_second: got len=%0d act=%0d, expected 64/2", n, fx_active_f);
        end
        n = 0;
        for (int i = 0; i < 40; i++) begin tick; if (busy_f) n++; end
        n_cmp++;
        if (n !== 0 || fx_active_f !== 2'd2) begin
            n_bad++;
            $display("FAIL pend_drop: got busy cycles=%0d act=%0d, expected 0/2", n, fx_active_f);
        end
    endtask

    task automatic test_cycle;
        int lat;
        reset = 1'b1;
        repeat (2) tick;
        reset = 1'b0;
        tick;
        set_paths(1000, -7, 12345, -32768);
        for (int k = 0; k < 4; k++) switch_and_check(k, lat);
        n_cmp++;
        if (fx_active !== 2'd0) begin
            n_bad++;
            $display("FAIL cycle_wrap: got %0d, expected 0", fx_active);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        logic signed [15:0] e;
        set_paths(111, 222, 333, 444);
        switch_and_check(0, lat);
        switch_and_check(1, lat);
        footswitch = 1'b1;
        lat = 0;
        while (busy !== 1'b1 && lat < 100) begin tick; lat++; end
        footswitch = 1'b0;
        repeat (5) tick;
        n_cmp++;
        if (busy !== 1'b1 || fx_active !== 2'd2) begin
            n_bad++;
            $display("FAIL mid_pre: got busy=%0b act=%0d, expected 1/2", busy, fx_active);
        end
        exp_q.delete();
        reset = 1'b1;
        exp_q.push_back(16'sd0);
        tick;
        e = exp_q.pop_front();
        n_cmp++;
        if (busy !== 1'b0 || fx_active !== 2'd0 || fx_flush !== 4'd0 || output_sample !== e) begin
            n_bad++;
            $display("FAIL mid_reset: got busy=%0b act=%0d flush=%b out=%0d, expected 0/0/0000/%0d",
                     busy, fx_active, fx_flush, output_sample, e);
        end
        reset = 1'b0;
        exp_q.push_back(16'(vals[0]));
        tick;
        e = exp_q.pop_front();
        n_cmp++;
        if (output_sample !== e || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_after: got out=%0d busy=%0b, expected %0d/0", output_sample, busy, e);
        end
    endtask

    initial begin
        footswitch   = 1'b0;
        footswitch_f = 1'b0;
        test_reset;
        test_debounce;
        test_switch;
        test_pending;
        test_cycle;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
